wreg_load_ctrl: RTL and testbench

- Sequences loading of one convolution kernel (NUM_WEIGHTS signed weights) from a valid/ready weight stream into a bank of negedge-capturing weight registers.
- Drives a broadcast data bus plus a one-hot per-register set vector, then holds Kernel_Valid until the MAC array releases the kernel.
- Sits between the weight memory/DMA and the weight register bank.

---
 rtl/wreg_load_ctrl_pkg.sv | 19 +
 rtl/wreg_load_ctrl_if.sv | 34 +++
 rtl/wlc_index_decoder.sv | 18 +
 rtl/wreg_load_ctrl.sv | 102 ++++++++++
 tb/tb_wreg_load_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wreg_load_ctrl_pkg.sv
// Shared types and constants for the weight-register load controller and the weight bank.
package wreg_load_ctrl_pkg;

  localparam int unsigned DefaultDataWidth  = 16;
  localparam int unsigned DefaultNumWeights = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2,
    StHold  = 2'd3
  } wlc_state_e;

  // Counter must be able to hold NUM_WEIGHTS itself (the HOLD value).
  function automatic int unsigned wlc_cnt_width(input int unsigned num_weights);
    return $clog2(num_weights + 1);
  endfunction

endpackage

// File: rtl/wreg_load_ctrl_if.sv
// Weight stream, register-bank drive and kernel handshake signals of the load controller.
interface wreg_load_ctrl_if
  import wreg_load_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned NUM_WEIGHTS = DefaultNumWeights,
  parameter int unsigned CNT_WIDTH   = wlc_cnt_width(NUM_WEIGHTS)
);

  logic                   WLC_Start;
  logic                   WLC_Abort;
  logic                   WLC_In_Valid;
  logic [DATA_WIDTH-1:0]  WLC_In_Data;
  logic                   WLC_In_Ready;
  logic [NUM_WEIGHTS-1:0] WLC_Set;
  logic [DATA_WIDTH-1:0]  WLC_Data;
  logic [CNT_WIDTH-1:0]   WLC_Load_Count;
  logic                   WLC_Busy;
  logic                   WLC_Kernel_Valid;
  logic                   WLC_Kernel_Release;

  // Side that requests loads, streams weights and releases kernels.
  modport master (
    output WLC_Start, WLC_Abort, WLC_In_Valid, WLC_In_Data, WLC_Kernel_Release,
    input  WLC_In_Ready, WLC_Set, WLC_Data, WLC_Load_Count, WLC_Busy, WLC_Kernel_Valid
  );

  // The load controller itself.
  modport slave (
    input  WLC_Start, WLC_Abort, WLC_In_Valid, WLC_In_Data, WLC_Kernel_Release,
    output WLC_In_Ready, WLC_Set, WLC_Data, WLC_Load_Count, WLC_Busy, WLC_Kernel_Valid
  );

endinterface

// File: rtl/wlc_index_decoder.sv
// Combinational index to one-hot decoder; out-of-range indices decode to all zeros.
module wlc_index_decoder #(
  parameter int unsigned NUM_OUT   = 9,
  parameter int unsigned IDX_WIDTH = 4
) (
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [NUM_OUT-1:0]   onehot
);

  // One bit per register, set only when the index matches.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (idx == IDX_WIDTH'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/wreg_load_ctrl.sv
// Sequences one kernel of weights from a valid/ready stream into a negedge-capturing
// register bank, then holds Kernel_Valid until the consumer releases it.
module wreg_load_ctrl
  import wreg_load_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned NUM_WEIGHTS = DefaultNumWeights,
  parameter int unsigned CNT_WIDTH   = wlc_cnt_width(NUM_WEIGHTS)
) (
  input logic              WLC_Clk,
  input logic              WLC_Reset,
  wreg_load_ctrl_if.slave  bus
);

  wlc_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_WEIGHTS-1:0] set_q, set_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [NUM_WEIGHTS-1:0] dec_onehot;
  logic                   in_ready;
  logic                   transfer;

  assign in_ready = (state_q == StLoad);
  assign transfer = bus.WLC_In_Valid & in_ready;

  wlc_index_decoder #(
    .NUM_OUT   (NUM_WEIGHTS),
    .IDX_WIDTH (CNT_WIDTH)
  ) u_index_decoder (
    .idx    (cnt_q),
    .onehot (dec_onehot)
  );

  // State, count and bank-drive registers; everything clears on reset.
  always_ff @(posedge WLC_Clk or negedge WLC_Reset) begin
    if (!WLC_Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      set_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; Set defaults to zero so every pulse lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = '0;
    data_d  = data_q;
    if (bus.WLC_Abort) begin
      // Abort beats everything, including a transfer offered in the same cycle.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.WLC_Start) begin
            state_d = StLoad;
            cnt_d   = '0;
          end
        end
        StLoad: begin
          if (transfer) begin
            data_d = bus.WLC_In_Data;
            set_d  = dec_onehot;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(NUM_WEIGHTS - 1)) state_d = StFlush;
          end
        end
        // Lets the last Set pulse be captured before Kernel_Valid rises.
        StFlush: state_d = StHold;
        StHold: begin
          if (bus.WLC_Kernel_Release) begin
            if (bus.WLC_Start) begin
              state_d = StLoad;
              cnt_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    bus.WLC_In_Ready     = in_ready;
    bus.WLC_Busy         = (state_q == StLoad) || (state_q == StFlush);
    bus.WLC_Kernel_Valid = (state_q == StHold);
    bus.WLC_Set          = set_q;
    bus.WLC_Data         = data_q;
    bus.WLC_Load_Count   = cnt_q;
  end

endmodule

// File: tb/tb_wreg_load_ctrl.sv
// Self-checking bench for wreg_load_ctrl: directed scenarios plus random traffic against a
// phase-level reference model and a negedge-capturing weight bank.
module tb_wreg_load_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 9;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;

  wreg_load_ctrl_if #(.DATA_WIDTH(DW), .NUM_WEIGHTS(NW), .CNT_WIDTH(CW)) bus ();

  wreg_load_ctrl #(
    .DATA_WIDTH  (DW),
    .NUM_WEIGHTS (NW),
    .CNT_WIDTH   (CW)
  ) dut (
    .WLC_Clk   (clk),
    .WLC_Reset (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight register bank as the real one behaves: capture on the falling edge.
  logic [DW-1:0] bank [NW];
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) if (bus.WLC_Set[i]) bank[i] <= bus.WLC_Data;
    end
  end

  // Reference model state
  string         m_phase;
  int            m_count;
  logic [NW-1:0] m_set;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_bank [NW];

  int n_cmp;
  int n_fail;
  int pulses;

  task automatic model_reset();
    m_phase = "idle";
    m_count = 0;
    m_set   = '0;
    m_data  = '0;
    for (int i = 0; i < NW; i++) exp_bank[i] = '0;
  endtask

  // What the controller does at one rising edge, from the behavioural rules.
  task automatic model_step(input logic s, input logic a, input logic v,
                            input logic [DW-1:0] d, input logic r);
    m_set = '0;
    if (a) begin
      m_phase = "idle";
      m_count = 0;
    end else if (m_phase == "idle") begin
      if (s) begin
        m_phase = "load";
        m_count = 0;
      end
    end else if (m_phase == "load") begin
      if (v) begin
        m_data = d;
        m_set = '0;
        m_set[m_count] = 1'b1;
        exp_bank[m_count] = d;
        m_count++;
        if (m_count == NW) m_phase = "flush";
      end
    end else if (m_phase == "flush") begin
      m_phase = "hold";
    end else if (r) begin
      if (s) begin
        m_phase = "load";
        m_count = 0;
      end else begin
        m_phase = "idle";
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".set"},   64'(bus.WLC_Set), 64'(m_set));
    chk({tag, ".data"},  64'(bus.WLC_Data), 64'(m_data));
    chk({tag, ".count"}, 64'(bus.WLC_Load_Count), 64'(m_count));
    chk({tag, ".ready"}, 64'(bus.WLC_In_Ready), 64'(m_phase == "load"));
    chk({tag, ".busy"},  64'(bus.WLC_Busy), 64'((m_phase == "load") || (m_phase == "flush")));
    chk({tag, ".kv"},    64'(bus.WLC_Kernel_Valid), 64'(m_phase == "hold"));
    n_cmp++;
    assert ($onehot0(bus.WLC_Set))
    else begin
      n_fail++;
      $error("FAIL %s.onehot: observed %0h expected at most one bit", tag, bus.WLC_Set);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NW; i++) chk($sformatf("%s.bank%0d", tag, i), 64'(bank[i]), 64'(exp_bank[i]));
  endtask

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic s, input logic a, input logic v,
                      input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    bus.WLC_Start          = s;
    bus.WLC_Abort          = a;
    bus.WLC_In_Valid       = v;
    bus.WLC_In_Data        = d;
    bus.WLC_Kernel_Release = r;
    model_step(s, a, v, d, r);
    @(posedge clk);
    #1;
    check_all(tag);
    if (bus.WLC_Set != '0) pulses++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic load_full(input string tag, input int base);
    step({tag, ".start"}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < NW; k++) step({tag, ".xfer"}, 1'b0, 1'b0, 1'b1, DW'(base + k), 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    pulses = 0;
    rst_n  = 1'b0;
    bus.WLC_Start          = 1'b0;
    bus.WLC_Abort          = 1'b0;
    bus.WLC_In_Valid       = 1'b0;
    bus.WLC_In_Data        = '0;
    bus.WLC_Kernel_Release = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset", 2);

    // Back-to-back weights 1..9, FLUSH, then HOLD
    load_full("b2b", 1);
    chk("b2b.flush_phase", 64'(bus.WLC_Busy & ~bus.WLC_In_Ready), 64'(1));
    idle("b2b.hold", 2);
    chk("b2b.kv", 64'(bus.WLC_Kernel_Valid), 64'(1));
    check_bank("b2b");

    // Release to IDLE; Release again while IDLE is ignored
    step("rel", 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step("rel_idle", 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Gappy stream of alternating-sign weights, with a stray Start mid-load
    pulses = 0;
    step("gap.start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < NW; k++) begin
      step("gap.xfer", (k == 3), 1'b0, 1'b1, DW'((k % 2 == 0) ? -(2 * k + 5) : (2 * k + 5)), 1'b0);
      step("gap.bubble", 1'b0, 1'b0, 1'b0, DW'(16'h7777), 1'b0);
    end
    idle("gap.hold", 2);
    chk("gap.pulses", 64'(pulses), 64'(NW));
    check_bank("gap");

    // Start alone in HOLD is ignored; Release+Start goes straight to LOAD
    step("hold.start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step("hold.relstart", 1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("hold.relstart.ready", 64'(bus.WLC_In_Ready), 64'(1));

    // Abort after four transfers, with a transfer presented on the abort cycle
    for (int k = 0; k < 4; k++) step("abort.xfer", 1'b0, 1'b0, 1'b1, DW'(100 + k), 1'b0);
    step("abort", 1'b1, 1'b1, 1'b1, DW'(16'hdead), 1'b0);
    idle("abort.after", 3);
    load_full("reload", 40);
    idle("reload.hold", 2);
    check_bank("reload");
    step("reload.rel", 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset between edges partway through a load
    step("arst.start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 6; k++) step("arst.xfer", 1'b0, 1'b0, 1'b1, DW'(200 + k), 1'b0);
    chk("arst.count6", 64'(bus.WLC_Load_Count), 64'(6));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    check_bank("arst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("arst.after", 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) == 0));
    end
    idle("rand.tail", 3);
    check_bank("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
